// File: rtl/shifter_seq.sv
// shifter_seq: iterative one-bit-per-cycle logical shifter with start/done handshake.
// SLL is always supported; defining SHIFTER_SRL_EN adds SRL (Signal=6'b000010)
// through the same engine. Unsupported codes take the same latency and return 0.
module shifter_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [5:0]  Signal,
  output logic        busy,
  output logic        done,
  output logic [31:0] dataOut
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;
  localparam int unsigned FW = 6;

  localparam logic [FW-1:0] FN_SLL = 6'b000000;
`ifdef SHIFTER_SRL_EN
  localparam logic [FW-1:0] FN_SRL = 6'b000010;
`endif

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  acc, acc_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [FW-1:0] fn, fn_nxt;
  logic [W-1:0]  out_nxt;
  logic          done_nxt;
  logic          busy_nxt;
  logic          fn_ok_c;

  // Only the low five bits of dataB form the shift amount.
  logic unused_datab_hi;
  assign unused_datab_hi = &{1'b0, dataB[W-1:CW]};

  // Latched function code decodes to a supported operation.
`ifdef SHIFTER_SRL_EN
  assign fn_ok_c = (fn == FN_SLL) || (fn == FN_SRL);
`else
  assign fn_ok_c = (fn == FN_SLL);
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      fn      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dataOut <= '0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      cnt     <= cnt_nxt;
      fn      <= fn_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      dataOut <= out_nxt;
    end
  end

  // Next-state, shift iteration and completion.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    fn_nxt    = fn;
    out_nxt   = dataOut;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          acc_nxt   = dataA;
          cnt_nxt   = dataB[CW-1:0];
          fn_nxt    = Signal;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
          if (fn == FN_SLL) begin
            acc_nxt = {acc[W-2:0], 1'b0};
          end
`ifdef SHIFTER_SRL_EN
          else if (fn == FN_SRL) begin
            acc_nxt = {1'b0, acc[W-1:1]};
          end
`endif
        end else begin
          out_nxt   = fn_ok_c ? acc : '0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt == SHIFT);
  end

endmodule

// File: doc/shifter_seq.md
# shifter_seq

Multi-cycle, one-bit-per-cycle shift engine for the ALU datapath. It performs shift-left-logical (SLL), the opposite direction of the existing combinational right shifter. It uses a start/done handshake so the controller can issue a shift and wait for the result. An optional build adds SRL through the same iterative engine, so both MIPS logical shifts share one sequential unit.

## Interface
- No parameters. Width is fixed at 32 bits.
- Shift amount is dataB[4:0]. dataB[31:5] is ignored.
- Function codes: SLL = 6'b000000; SRL = 6'b000010 (SRL only with `SHIFTER_SRL_EN`).

Ports:
- clk  input  1  — single clock; all state updates on its rising edge.
- reset  input  1  — asynchronous, active-low.
- start  input  1  — request; sampled only in IDLE.
- dataA  input  32  — operand to shift; sampled with start.
- dataB  input  32  — shift amount in [4:0]; sampled with start.
- Signal  input  6  — function code; sampled with start.
- busy  output  1  — high while in SHIFT.
- done  output  1  — one-cycle pulse when dataOut is updated.
- dataOut  output  32  — registered result; holds until the next completion.

## Operation
- States and transitions:
  - IDLE: when start=1, go to SHIFT. Ignore start otherwise.
  - SHIFT: iterate the shift; go to IDLE on completion.
- Accept in IDLE:
  - Latch work register acc=dataA, counter cnt=dataB[4:0] (5 bits) and the function code.
  - Go to SHIFT.
- SHIFT, cnt≠0, SLL: acc <= {acc[30:0],1'b0}; cnt <= cnt-1.
- SHIFT, cnt≠0, SRL (macro on): acc <= {1'b0,acc[31:1]}; cnt <= cnt-1.
- SHIFT, cnt=0:
  - dataOut <= acc; done <= 1; go to IDLE.
  - Unsupported code: dataOut <= 32'h0000_0000 instead, done still pulses.
- An unsupported code is latched normally, but acc is not shifted and cnt counts down unchanged, so latency is the same as a valid op.
- start while busy=1 is ignored. No queuing and no effect on the current op.
- Inputs are needed only on the accept cycle. The caller may change them afterwards.
- Reset (any time, including mid-shift), all at once:
  - state=IDLE, busy=0, done=0, dataOut=0, acc=0, cnt=0.
  - The in-flight op is discarded and no done is produced.

## Timing
- Edge E0 samples start=1 in IDLE. busy is high from after E0.
- Edges E1..E_n shift, where n = dataB[4:0].
- Edge E_(n+1):
  - dataOut is updated, done goes high and busy goes low.
  - done stays high for exactly one cycle.
- Latency from the accept edge to done is n+1 cycles:
  - minimum 1 cycle (n=0);
  - maximum 32 cycles (n=31).
- Back-to-back: start=1 in the cycle where done=1 (already in IDLE) is accepted at the next edge. Throughput is one op per n+1 cycles.
- dataOut changes only at a done edge or at reset. It is never in an intermediate state.
- Reset values: busy=0, done=0, dataOut=32'h0000_0000.

## Configuration
- `SHIFTER_SRL_EN`
  - Defined: Signal=6'b000010 is a supported code and shifts right logical, zero-fill, with the same latency and handshake as SLL.
  - Undefined: 6'b000010 is unsupported. It takes the same n+1 cycles and completes with dataOut=0.
- SLL behaviour is identical in both builds.

## Test plan
- Reset low for 3 cycles, then release:
  - busy=0, done=0, dataOut=0 during and after reset;
  - start=0 leaves busy and done at 0.
- SLL limits:
  - dataA=32'h0000_0001, dataB=31 → done exactly 32 cycles after accept, dataOut=32'h8000_0000;
  - dataA=32'hDEAD_BEEF, dataB=0 → done 1 cycle after accept, dataOut=32'hDEAD_BEEF;
  - dataB=32'hFFFF_FFE4 → shift amount 4 (upper bits ignored).
- Overlap and back-to-back:
  - dataA=32'h0000_00FF, dataB=8 → dataOut=32'h0000_FF00 at 9 cycles;
  - a second start pulsed mid-op with different operands is ignored;
  - a third start issued in the done cycle completes correctly.
- Reset mid-op:
  - reset asserted 3 cycles into a dataB=20 SLL → immediate busy=0, dataOut=0, no done pulse;
  - a fresh op after release works.
- Macro on: Signal=6'b000010, dataA=32'h8000_0000, dataB=31 → dataOut=32'h0000_0001 at 32 cycles.
- Macro off: the same stimulus gives dataOut=0 at 32 cycles.
- Unsupported Signal=6'b100000, dataB=5 → done after 6 cycles, dataOut=0.
